// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller:
// FSM encoding, block/word geometry and address-field widths.
package dcache_ctrl_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int BLOCK_W    = 256;
    localparam int OFFSET_W   = 5;   // byte offset within a 32-byte block
    localparam int BYTE_OFF_W = 2;   // byte offset within a word
    localparam int WORD_SEL_W = OFFSET_W - BYTE_OFF_W;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_MISS          = 3'd1,
        ST_WRITEBACK     = 3'd2,
        ST_ALLOCATE      = 3'd3,
        ST_ALLOCATE_DONE = 3'd4
    } state_e;

    function automatic int tag_width(input int idx_w);
        return ADDR_W - OFFSET_W - idx_w;
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Line storage: valid/dirty flags (async cleared), tag and block arrays.
// Combinational read on rd_idx, single synchronous write port that always sets valid.
module dcache_sram
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = tag_width(IDX_W)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_data,
    input  logic               wr_dirty
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_q [NUM_LINES];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    // Tag and data contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         p1_req_i,
    input  logic         p1_write_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o,
`endif
    output logic [2:0]   state_o
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = tag_width(IDX_W);

    // Memory handshake: mem_enable_o is a level request held with stable
    // mem_write_o/mem_addr_o/mem_data_o until mem_ack_i is sampled high for
    // one cycle; the request drops in the following cycle. Acks outside
    // WRITEBACK/ALLOCATE are ignored.

    state_e state_q, state_d;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [WORD_SEL_W-1:0] word_sel;
    logic                  line_valid, line_dirty;
    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_W-1:0]    line_data, merged_data, wr_data;
    logic                  wr_en, wr_dirty;
    logic                  hit, idle_hit, idle_miss, stall;
    logic                  unused_addr;

    assign req_idx     = p1_addr_i[OFFSET_W +: IDX_W];
    assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign word_sel    = p1_addr_i[OFFSET_W-1:BYTE_OFF_W];
    assign unused_addr = ^p1_addr_i[BYTE_OFF_W-1:0];

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_sram (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx   (req_idx),
        .rd_valid (line_valid),
        .rd_dirty (line_dirty),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_data  (wr_data),
        .wr_dirty (wr_dirty)
    );

    assign hit       = p1_req_i & line_valid & (line_tag == req_tag);
    assign idle_hit  = (state_q == ST_IDLE) & hit;
    assign idle_miss = (state_q == ST_IDLE) & p1_req_i & ~hit;

    always_comb begin
        merged_data = line_data;
        merged_data[word_sel*WORD_W +: WORD_W] = p1_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        wr_en        = 1'b0;
        wr_dirty     = 1'b0;
        wr_data      = merged_data;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    wr_en    = p1_write_i;
                    wr_dirty = 1'b1;
                end else if (p1_req_i) begin
                    stall   = 1'b1;
                    state_d = ST_MISS;
                end
            end
            ST_MISS: begin
                stall   = 1'b1;
                state_d = (line_valid && line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
            end
            ST_WRITEBACK: begin
                stall        = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {line_tag, req_idx, {OFFSET_W{1'b0}}};
                mem_data_o   = line_data;
                if (mem_ack_i) state_d = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                stall        = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, req_idx, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    wr_en    = 1'b1;
                    wr_dirty = 1'b0;
                    wr_data  = mem_data_i;
                    state_d  = ST_ALLOCATE_DONE;
                end
            end
            ST_ALLOCATE_DONE: begin
                stall   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall is combinational on the request, so mask it while reset is held.
    assign p1_stall_o = rst_i & stall;
    assign p1_data_o  = (idle_hit && !p1_write_i) ? line_data[word_sel*WORD_W +: WORD_W] : '0;
    assign state_o    = state_q;

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (idle_hit && hit_cnt_o != 32'hFFFF_FFFF)   hit_cnt_o  <= hit_cnt_o + 32'd1;
            if (idle_miss && miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold miss, store/load hits, dirty eviction,
// reset abort and idle spurious acks, with hand-computed expectations.
module tb_dcache_ctrl;
    import dcache_ctrl_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         p1_req_i, p1_write_i;
    logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
    logic         p1_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic [2:0]   state_o;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    dcache_ctrl #(.NUM_LINES(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p1_req_i     (p1_req_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
`ifdef DCACHE_STATS_EN
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o),
`endif
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory image: word w of the block at address a holds 0xA000_0000 | (a + 4w).
    function automatic logic [255:0] mem_block(input logic [31:0] a);
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[w*32 +: 32] = 32'hA000_0000 | (a + 32'(4 * w));
        return b;
    endfunction

    task automatic drive(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk_i);
        p1_req_i   = req;
        p1_write_i = wr;
        p1_addr_i  = addr;
        p1_data_i  = data;
        #1;
    endtask

    task automatic mem_ack_pulse(input logic [255:0] data);
        mem_ack_i  = 1'b1;
        mem_data_i = data;
        @(negedge clk_i);
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        #1;
    endtask

    // Called right after a missing request was driven; returns in the replay cycle.
    task automatic do_miss(input bit exp_wb, input logic [31:0] wb_addr,
                           input logic [31:0] wb_word1, input logic [31:0] fetch_addr);
        check("miss_stall", p1_stall_o, 1'b1);
        @(negedge clk_i); #1;
        check("st_miss", state_o, ST_MISS);
        check("miss_no_mem", mem_enable_o, 1'b0);
        @(negedge clk_i); #1;
        if (exp_wb) begin
            check("st_wb", state_o, ST_WRITEBACK);
            check("wb_en", mem_enable_o, 1'b1);
            check("wb_write", mem_write_o, 1'b1);
            check("wb_addr", mem_addr_o, wb_addr);
            check("wb_word1", mem_data_o[63:32], wb_word1);
            repeat (3) @(negedge clk_i);
            mem_ack_pulse('0);
        end
        check("st_alloc", state_o, ST_ALLOCATE);
        check("alloc_en", mem_enable_o, 1'b1);
        check("alloc_write", mem_write_o, 1'b0);
        check("alloc_addr", mem_addr_o, fetch_addr);
        repeat (10) @(negedge clk_i);
        #1 check("alloc_en_held", mem_enable_o, 1'b1);
        mem_ack_pulse(mem_block(fetch_addr));
        check("st_alloc_done", state_o, ST_ALLOCATE_DONE);
        check("done_en_low", mem_enable_o, 1'b0);
        check("done_stall", p1_stall_o, 1'b1);
        @(negedge clk_i); #1;
        check("replay_idle", state_o, ST_IDLE);
        check("replay_stall", p1_stall_o, 1'b0);
    endtask

    initial begin
        rst_i      = 1'b0;
        p1_req_i   = 1'b0;
        p1_write_i = 1'b0;
        p1_addr_i  = '0;
        p1_data_i  = '0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_state", state_o, ST_IDLE);
        check("rst_stall", p1_stall_o, 1'b0);
        check("rst_en", mem_enable_o, 1'b0);
        check("rst_wr", mem_write_o, 1'b0);
`ifdef DCACHE_STATS_EN
        check("rst_hits", hit_cnt_o, 32'd0);
        check("rst_misses", miss_cnt_o, 32'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b1;

        // Cold load of 0x40: fetch without write-back.
        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        do_miss(1'b0, 32'h0, 32'h0, 32'h0000_0040);
        check("cold_load_data", p1_data_o, 32'hA000_0040);

        // Store hit then load hit on the resident line.
        drive(1'b1, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
        check("store_hit_stall", p1_stall_o, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        check("load_hit_stall", p1_stall_o, 1'b0);
        check("load_hit_data", p1_data_o, 32'hDEAD_BEEF);

        // Conflicting load 0x440 evicts the dirty line at 0x40.
        drive(1'b1, 1'b0, 32'h0000_0440, 32'h0);
        do_miss(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0440);
        check("evict_load_data", p1_data_o, 32'hA000_0440);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("idle_data_zero", p1_data_o, 32'h0);
`ifdef DCACHE_STATS_EN
        check("stat_hits", hit_cnt_o, 32'd4);
        check("stat_misses", miss_cnt_o, 32'd2);
`endif
        drive(1'b1, 1'b0, 32'h0000_0444, 32'h0);
        check("word1_hit_data", p1_data_o, 32'hA000_0444);

        // Reset pulse in ALLOCATE, then a late ack.
        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        check("pre_rst_stall", p1_stall_o, 1'b1);
        @(negedge clk_i); #1;
        @(negedge clk_i); #1;
        check("pre_rst_alloc", state_o, ST_ALLOCATE);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("abort_state", state_o, ST_IDLE);
        check("abort_en", mem_enable_o, 1'b0);
        check("abort_stall", p1_stall_o, 1'b0);
        @(negedge clk_i);
        p1_req_i = 1'b0;
        rst_i    = 1'b1;
        repeat (2) @(negedge clk_i);
        mem_ack_pulse(mem_block(32'h0000_0040));
        check("late_ack_state", state_o, ST_IDLE);
        check("late_ack_en", mem_enable_o, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        do_miss(1'b0, 32'h0, 32'h0, 32'h0000_0040);
        check("refetch_data", p1_data_o, 32'hA000_0040);

        // Idle with spurious acks.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            p1_req_i  = 1'b0;
            mem_ack_i = (i % 3 == 0);
            #1;
            check("idle_state", state_o, ST_IDLE);
            check("idle_stall", p1_stall_o, 1'b0);
            check("idle_en", mem_enable_o, 1'b0);
            check("idle_data", p1_data_o, 32'h0);
        end
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        check("post_idle_stall", p1_stall_o, 1'b0);
        check("post_idle_data", p1_data_o, 32'hA000_0044);
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter: NUM_LINES, default 32, number of direct-mapped lines; power of two, 2..256.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-low.
REQ-004 p1_req_i  input  1  MEM-stage access request (load or store).
REQ-005 p1_write_i  input  1  1 = store, 0 = load; valid only with p1_req_i.
REQ-006 p1_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-007 p1_data_i  input  32  store data.
REQ-008 p1_data_o  output  32  load data.
REQ-009 p1_stall_o  output  1  freezes all pipeline registers while high.
REQ-010 mem_enable_o  output  1  memory request valid.
REQ-011 mem_write_o  output  1  1 = block write-back, 0 = block fetch.
REQ-012 mem_addr_o  output  32  block-aligned address; bits [4:0] zero.
REQ-013 mem_data_o  output  256  write-back block.
REQ-014 mem_data_i  input  256  fetched block; valid when mem_ack_i high.
REQ-015 mem_ack_i  input  1  single-cycle completion pulse from memory.

Function
REQ-016 Organisation: write-back, write-allocate; 32-byte blocks; offset [4:0], index [4+log2(NUM_LINES):5], tag = remaining upper bits; each line holds valid, dirty, tag, 256-bit data.
REQ-017 Hit = p1_req_i & valid & tag match, decided combinationally in the request cycle.
REQ-018 Load hit: p1_data_o = addressed word, same cycle, p1_stall_o low; zero-latency.
REQ-019 Store hit: addressed word written and dirty set at the next rising edge; p1_stall_o low.
REQ-020 Miss: p1_stall_o high combinationally in the request cycle and held until the access completes as a hit in IDLE.
REQ-021 FSM states: IDLE, MISS, WRITEBACK, ALLOCATE, ALLOCATE_DONE.
REQ-022 IDLE -> MISS on p1_req_i & ~hit; otherwise stays IDLE.
REQ-023 MISS -> WRITEBACK if victim valid & dirty, else -> ALLOCATE; no memory request in MISS.
REQ-024 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim block; on mem_ack_i -> ALLOCATE.
REQ-025 ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}; on mem_ack_i line loaded with mem_data_i, valid=1, dirty=0, tag=req tag -> ALLOCATE_DONE.
REQ-026 ALLOCATE_DONE: mem_enable_o=0 -> IDLE; request replays as a hit (store hit then sets dirty).
REQ-027 mem_enable_o drops in the cycle after mem_ack_i is sampled; mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
REQ-028 p1_req_i, p1_addr_i, p1_write_i and p1_data_i are held stable by the stalled pipeline; the controller does not latch them.
REQ-029 p1_req_i low: p1_stall_o low, p1_data_o zero, no state change.

Reset
REQ-030 rst_i low: FSM to IDLE, all valid and dirty bits cleared, mem_enable_o=0, mem_write_o=0, p1_stall_o=0; tag/data arrays need not be cleared.
REQ-031 Reset mid-miss aborts the transaction; any subsequent mem_ack_i is ignored.

Configuration
REQ-032 Macro DCACHE_STATS_EN: defined -> outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], saturating counters, zero on reset, hit_cnt_o +1 per hit in IDLE (including replays), miss_cnt_o +1 per IDLE->MISS transition; undefined -> ports and counters absent, behaviour otherwise identical.

Structure
REQ-033 Shared package: FSM state encoding, block/offset width constants, and the address-field slicing widths.
REQ-034 One sub-module dcache_sram: tag/valid/dirty/data storage, combinational read, synchronous write, asynchronous valid/dirty clear.

Verification
REQ-035 Cold load 0x0000_0040 -> stall high, one ALLOCATE fetch at 0x40 without prior write-back, ack after 10 cycles, stall low in the cycle after ALLOCATE_DONE with data word 0.
REQ-036 Store 0xDEADBEEF to 0x44 (line resident) -> no stall; subsequent load 0x44 returns 0xDEADBEEF same cycle.
REQ-037 Load 0x0000_0440 (same index as 0x40, NUM_LINES=32, line dirty) -> WRITEBACK to 0x40 carrying 0xDEADBEEF, then fetch 0x440.
REQ-038 rst_i pulsed low during ALLOCATE, then late mem_ack_i -> ignored; FSM IDLE; load 0x40 misses again.
REQ-039 p1_req_i low for 20 cycles with spurious mem_ack_i -> no state change, stall low, mem_enable_o low.
REQ-040 With DCACHE_STATS_EN: after REQ-035..037 sequence hit_cnt_o=4, miss_cnt_o=2.
